// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2
  } fetch_state_t;

  localparam int INSTR_W = 32;
  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 21;
  localparam int PC_INCR = 4;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: async active-low reset to RESET_PC, loads d when load=1.
module pc_reg #(
  parameter int             N        = 64,
  parameter logic [N-1:0]   RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] pc_r;

  // PC storage; holds its value unless a new PC is loaded
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r <= RESET_PC;
    end else if (load) begin
      pc_r <= d;
    end else begin
      pc_r <= pc_r;
    end
  end

  assign q = pc_r;

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 fetch stage: PC, single-outstanding req/ack fetch from instruction memory,
// registered instruction handed to decode over valid/ready, with branch redirection on retire.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int           N        = 64,
  parameter logic [N-1:0] RESET_PC = '0,
  parameter int           CNT_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [N-1:0]       imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               id_valid,
  input  logic               id_ready,
  input  logic               pc_src,
  input  logic [N-1:0]       pc_branch,
  output logic [INSTR_W-1:0] instr,
  output logic [10:0]        Op,
  output logic [N-1:0]       pc_out,
  output logic [CNT_W-1:0]   instr_count
);

  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("fetch_stage: RESET_PC must be word-aligned");
  end

  localparam logic [N-1:0] WORD_MASK = ~{{(N-2){1'b0}}, 2'b11};

  fetch_state_t       state_r;
  fetch_state_t       state_next_s;
  logic               imem_req_r;
  logic               id_valid_r;
  logic [INSTR_W-1:0] instr_r;
  logic [N-1:0]       pc_out_r;
  logic [CNT_W-1:0]   instr_count_r;
  logic [N-1:0]       pc_s;
  logic [N-1:0]       pc_next_s;
  logic               pc_load_s;
  logic               fetch_done_s;
  logic               retire_s;

  pc_reg #(
    .N        (N),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk   (clk),
    .reset (reset),
    .load  (pc_load_s),
    .d     (pc_next_s),
    .q     (pc_s)
  );

  // Next-state, next-PC select and transfer strobes
  always_comb begin
    state_next_s = state_r;
    pc_load_s    = 1'b0;
    pc_next_s    = pc_s + N'(PC_INCR);
    fetch_done_s = 1'b0;
    retire_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        state_next_s = S_REQ;
      end
      S_REQ: begin
        if (imem_ack) begin
          fetch_done_s = 1'b1;
          pc_load_s    = 1'b1;
          state_next_s = S_VALID;
        end else begin
          state_next_s = S_REQ;
        end
      end
      S_VALID: begin
        if (id_ready) begin
          retire_s     = 1'b1;
          state_next_s = S_REQ;
          // A taken branch overrides the sequential PC already loaded on fetch
          if (pc_src) begin
            pc_load_s = 1'b1;
            pc_next_s = pc_branch & WORD_MASK;
          end else begin
            pc_load_s = 1'b0;
          end
        end else begin
          state_next_s = S_VALID;
        end
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // State register with handshake outputs registered from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= S_IDLE;
      imem_req_r <= 1'b0;
      id_valid_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      imem_req_r <= (state_next_s == S_REQ);
      id_valid_r <= (state_next_s == S_VALID);
    end
  end

  // Instruction/PC capture on fetch completion, retire counter on handshake
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_r       <= '0;
      pc_out_r      <= '0;
      instr_count_r <= '0;
    end else begin
      if (fetch_done_s) begin
        instr_r  <= imem_rdata;
        pc_out_r <= pc_s;
      end
      if (retire_s) begin
        instr_count_r <= instr_count_r + CNT_W'(1);
      end
    end
  end

  assign imem_req    = imem_req_r;
  assign imem_addr   = pc_s;
  assign id_valid    = id_valid_r;
  assign instr       = instr_r;
  assign Op          = instr_r[OP_MSB:OP_LSB];
  assign pc_out      = pc_out_r;
  assign instr_count = instr_count_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, reset/wrap sequences,
// and randomized fetch traffic compared against a transaction-level PC/instruction model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, imem_ack, id_ready, pc_src;
  logic        imem_req, id_valid;
  logic [63:0] imem_addr, pc_branch, pc_out;
  logic [31:0] imem_rdata, instr, instr_count;
  logic [10:0] Op;

  logic        reset1, imem_ack1, id_ready1, pc_src1;
  logic        imem_req1, id_valid1;
  logic [63:0] imem_addr1, pc_branch1, pc_out1;
  logic [31:0] imem_rdata1, instr1;
  logic [3:0]  instr_count1;
  logic [10:0] Op1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .id_valid(id_valid),
    .id_ready(id_ready), .pc_src(pc_src), .pc_branch(pc_branch), .instr(instr),
    .Op(Op), .pc_out(pc_out), .instr_count(instr_count)
  );

  fetch_stage #(.N(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset1), .imem_req(imem_req1), .imem_addr(imem_addr1),
    .imem_ack(imem_ack1), .imem_rdata(imem_rdata1), .id_valid(id_valid1),
    .id_ready(id_ready1), .pc_src(pc_src1), .pc_branch(pc_branch1), .instr(instr1),
    .Op(Op1), .pc_out(pc_out1), .instr_count(instr_count1)
  );

  typedef struct {
    logic [31:0] rdata;
    int          delay;
    int          stall;
    logic        src;
    logic [63:0] branch;
    logic [63:0] exp_addr;
    logic [10:0] exp_op;
  } vec_t;

  vec_t  vecs[5];
  logic [63:0] model_pc;
  int unsigned model_cnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction on dut: request (with delay wait cycles), valid, stall, accept.
  task automatic do_fetch(input logic [31:0] rdata, input int delay, input int stall,
                          input logic src, input logic [63:0] branch,
                          input logic [63:0] exp_addr, input logic [10:0] exp_op);
    chk("req_start", {63'd0, imem_req}, 64'd1);
    chk("addr_start", imem_addr, exp_addr);
    for (int i = 0; i < delay; i++) begin
      imem_ack = 1'b0;
      imem_rdata = $urandom;
      tick();
      chk("req_hold", {63'd0, imem_req}, 64'd1);
      chk("addr_hold", imem_addr, exp_addr);
      chk("valid_low", {63'd0, id_valid}, 64'd0);
    end
    imem_ack = 1'b1;
    imem_rdata = rdata;
    tick();
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    chk("valid_up", {63'd0, id_valid}, 64'd1);
    chk("req_down", {63'd0, imem_req}, 64'd0);
    chk("instr", {32'd0, instr}, {32'd0, rdata});
    chk("op", {53'd0, Op}, {53'd0, exp_op});
    chk("pc_out", pc_out, exp_addr);
    chk("count_valid", {32'd0, instr_count}, {32'd0, model_cnt});
    for (int i = 0; i < stall; i++) begin
      id_ready  = 1'b0;
      pc_src    = 1'b1;
      pc_branch = {$urandom, $urandom};
      imem_ack  = 1'($urandom_range(0, 1));
      tick();
      chk("stall_valid", {63'd0, id_valid}, 64'd1);
      chk("stall_req", {63'd0, imem_req}, 64'd0);
      chk("stall_instr", {32'd0, instr}, {32'd0, rdata});
      chk("stall_op", {53'd0, Op}, {53'd0, exp_op});
      chk("stall_pc_out", pc_out, exp_addr);
      chk("stall_count", {32'd0, instr_count}, {32'd0, model_cnt});
    end
    id_ready  = 1'b1;
    pc_src    = src;
    pc_branch = branch;
    tick();
    id_ready = 1'b0;
    pc_src   = 1'b0;
    imem_ack = 1'b0;
    model_cnt++;
    model_pc = src ? (branch / 64'd4) * 64'd4 : exp_addr + 64'd4;
    chk("accept_req", {63'd0, imem_req}, 64'd1);
    chk("accept_valid", {63'd0, id_valid}, 64'd0);
    chk("accept_count", {32'd0, instr_count}, {32'd0, model_cnt});
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    imem_ack = 1'b0; id_ready = 1'b0; pc_src = 1'b0; pc_branch = '0; imem_rdata = '0;
    tick();
    tick();
    chk("rst_req", {63'd0, imem_req}, 64'd0);
    chk("rst_valid", {63'd0, id_valid}, 64'd0);
    chk("rst_instr", {32'd0, instr}, 64'd0);
    chk("rst_op", {53'd0, Op}, 64'd0);
    chk("rst_pc_out", pc_out, 64'd0);
    chk("rst_count", {32'd0, instr_count}, 64'd0);
    chk("rst_addr", imem_addr, 64'd0);
    reset = 1'b1;
    tick();
    model_pc = 64'd0;
    model_cnt = 0;
  endtask

  initial begin
    vecs[0] = '{32'hF840_0000, 0, 0, 1'b0, 64'h0,   64'h0,   11'b111_1100_0010};
    vecs[1] = '{32'h8B02_0020, 3, 5, 1'b0, 64'h0,   64'h4,   11'h458};
    vecs[2] = '{32'hB400_0040, 1, 0, 1'b1, 64'h103, 64'h8,   11'h5A0};
    vecs[3] = '{32'hD280_0000, 0, 2, 1'b0, 64'h0,   64'h100, 11'h694};
    vecs[4] = '{32'hF800_0000, 2, 1, 1'b0, 64'h0,   64'h104, 11'h7C0};

    reset1 = 1'b0; imem_ack1 = 1'b0; id_ready1 = 1'b0; pc_src1 = 1'b0;
    pc_branch1 = '0; imem_rdata1 = '0;

    // Directed table
    reset_dut();
    for (int v = 0; v < 5; v++) begin
      chk("model_addr", model_pc, vecs[v].exp_addr);
      do_fetch(vecs[v].rdata, vecs[v].delay, vecs[v].stall, vecs[v].src,
               vecs[v].branch, vecs[v].exp_addr, vecs[v].exp_op);
    end

    // Reset in the middle of a request at 0x10, with an ack during reset
    reset_dut();
    for (int k = 0; k < 4; k++) begin
      logic [31:0] w;
      w = $urandom | 32'h8000_0000;
      do_fetch(w, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, 64'h0, model_pc, w[31:21]);
    end
    chk("mid_addr", imem_addr, 64'h10);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_req_drop", {63'd0, imem_req}, 64'd0);
    chk("mid_instr", {32'd0, instr}, 64'd0);
    chk("mid_pc_out", pc_out, 64'd0);
    chk("mid_count", {32'd0, instr_count}, 64'd0);
    chk("mid_addr_rst", imem_addr, 64'd0);
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    chk("ack_in_rst_valid", {63'd0, id_valid}, 64'd0);
    chk("ack_in_rst_instr", {32'd0, instr}, 64'd0);
    reset = 1'b1;
    chk("idle_req", {63'd0, imem_req}, 64'd0);
    tick();
    model_pc = 64'd0;
    model_cnt = 0;

    // Randomized traffic against the transaction model
    for (int t = 0; t < 40; t++) begin
      logic [31:0] w;
      logic        s;
      logic [63:0] b;
      w = $urandom;
      s = ($urandom_range(0, 3) == 0);
      b = {$urandom, $urandom};
      do_fetch(w, $urandom_range(0, 3), $urandom_range(0, 3), s, b, model_pc, w[31:21]);
    end

    // PC wrap and 4-bit counter wrap on the second instance
    reset1 = 1'b1;
    tick();
    chk("wrap_req", {63'd0, imem_req1}, 64'd1);
    chk("wrap_first_addr", imem_addr1, 64'hFFFF_FFFF_FFFF_FFFC);
    for (int k = 1; k <= 16; k++) begin
      imem_ack1 = 1'b1;
      imem_rdata1 = $urandom;
      tick();
      imem_ack1 = 1'b0;
      if (k == 1) chk("wrap_pc_out", pc_out1, 64'hFFFF_FFFF_FFFF_FFFC);
      id_ready1 = 1'b1;
      tick();
      id_ready1 = 1'b0;
      chk("wrap_addr", imem_addr1, 64'(k - 1) * 64'd4);
      chk("wrap_count", {60'd0, instr_count1}, 64'(k % 16));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
